// File: rtl/vscale_ifetch.sv
`default_nettype none
// ============================================================================
//  Module      : vscale_ifetch
//  Description : Credit-based instruction fetch stage. Issues in-order imem
//                requests, tags them with an epoch so that responses fetched
//                before a redirect are discarded, and buffers returned
//                instructions in a 2-entry FIFO toward decode.
//                Optional feature macro: VSCALE_IFETCH_MISALIGN_TRAP_EN
//                (misaligned PC produces a trap entry instead of a request).
//  Revision    : 1.0 - initial release
// ============================================================================
module vscale_ifetch #(
    parameter logic [31:0] START_ADDR = 32'h200
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PC_PIF,
    input  logic        redirect,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic [31:0] PC_IF,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_PC,
    output logic        inst_misaligned,
    output logic        protocol_err
);

    localparam logic [2:0] c_MAX_CREDITS = 3'd2;

    // Fetch PC, epoch and sticky error
    logic [31:0] pc_q, pc_d;
    logic        epoch_q, epoch_d;
    logic        perr_q, perr_d;

    // In-flight request queue: {epoch, address}
    logic [32:0] ifq_q [2];
    logic        ifq_wp_q, ifq_wp_d, ifq_rp_q, ifq_rp_d;
    logic [1:0]  ifq_cnt_q, ifq_cnt_d;

    // Instruction FIFO: {address, data}
    logic [63:0] fifo_q [2];
    logic        fifo_wp_q, fifo_wp_d, fifo_rp_q, fifo_rp_d;
    logic [1:0]  fifo_cnt_q, fifo_cnt_d;

    logic [2:0]  w_credits_eff;
    logic        w_credit_ok;
    logic        w_fetch_ok;
    logic        w_accept;
    logic        w_resp_pop;
    logic        w_resp_keep;
    logic        w_trap_push;
    logic        w_fifo_push;
    logic        w_fifo_pop;
    logic [32:0] w_ifq_head;
    logic [63:0] w_push_entry;

    // A pop this cycle frees its credit immediately, so a 1-cycle memory
    // keeps a sustained stream with only two credits.
    assign w_fifo_pop    = inst_valid & inst_ready;
    assign w_credits_eff = {1'b0, ifq_cnt_q} + {1'b0, fifo_cnt_q} - {2'b00, w_fifo_pop};
    assign w_credit_ok   = (w_credits_eff < c_MAX_CREDITS);

    assign imem_req_valid = ~reset & w_credit_ok & w_fetch_ok;
    assign w_accept       = imem_req_valid & imem_req_ready;

    // Responses are in order; a response with nothing outstanding is ignored.
    assign w_ifq_head  = ifq_q[ifq_rp_q];
    assign w_resp_pop  = imem_resp_valid & (ifq_cnt_q != 2'd0);
    assign w_resp_keep = w_resp_pop & ~redirect & (w_ifq_head[32] == epoch_q);
    assign w_fifo_push = w_resp_keep | w_trap_push;
    assign w_push_entry = w_resp_keep ? {w_ifq_head[31:0], imem_resp_data}
                                      : {pc_q, 32'h0};

    assign PC_IF        = pc_q;
    assign protocol_err = perr_q;
    assign inst_valid   = (fifo_cnt_q != 2'd0);
    assign inst_PC      = fifo_q[fifo_rp_q][63:32];
    assign inst_data    = fifo_q[fifo_rp_q][31:0];

`ifdef VSCALE_IFETCH_MISALIGN_TRAP_EN
    logic stall_q, stall_d;
    logic fifo_mis_q [2];
    logic w_mis;

    // Trap entry waits for older requests to retire so it never collides
    // with a response push; afterwards fetch stalls until a redirect.
    assign w_mis           = (pc_q[1:0] != 2'b00);
    assign w_fetch_ok      = ~w_mis;
    assign w_trap_push     = w_mis & ~stall_q & ~redirect & (ifq_cnt_q == 2'd0) & w_credit_ok;
    assign imem_addr       = pc_q;
    assign inst_misaligned = inst_valid & fifo_mis_q[fifo_rp_q];
    assign stall_d         = redirect ? 1'b0 : (stall_q | w_trap_push);

    // Stall flag register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) stall_q <= 1'b0;
        else       stall_q <= stall_d;
    end

    // Misaligned flag storage alongside the FIFO entries
    always_ff @(posedge clk) begin
        if (w_fifo_push) fifo_mis_q[fifo_wp_q] <= w_trap_push;
    end
`else
    assign w_fetch_ok      = 1'b1;
    assign w_trap_push     = 1'b0;
    assign imem_addr       = {pc_q[31:2], 2'b00};
    assign inst_misaligned = 1'b0;
`endif

    // Next-state computation for PC, epoch, error flag and queue pointers
    always_comb begin
        pc_d       = pc_q;
        epoch_d    = epoch_q ^ redirect;
        perr_d     = perr_q | (imem_resp_valid & (ifq_cnt_q == 2'd0));
        ifq_wp_d   = ifq_wp_q ^ w_accept;
        ifq_rp_d   = ifq_rp_q ^ w_resp_pop;
        ifq_cnt_d  = ifq_cnt_q + {1'b0, w_accept} - {1'b0, w_resp_pop};
        fifo_wp_d  = fifo_wp_q ^ w_fifo_push;
        fifo_rp_d  = fifo_rp_q ^ w_fifo_pop;
        fifo_cnt_d = fifo_cnt_q + {1'b0, w_fifo_push} - {1'b0, w_fifo_pop};
        if (redirect || w_accept) begin
            pc_d = PC_PIF;
        end
        if (redirect) begin
            fifo_wp_d  = 1'b0;
            fifo_rp_d  = 1'b0;
            fifo_cnt_d = 2'd0;
        end
    end

    // Control state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q       <= START_ADDR;
            epoch_q    <= 1'b0;
            perr_q     <= 1'b0;
            ifq_wp_q   <= 1'b0;
            ifq_rp_q   <= 1'b0;
            ifq_cnt_q  <= 2'd0;
            fifo_wp_q  <= 1'b0;
            fifo_rp_q  <= 1'b0;
            fifo_cnt_q <= 2'd0;
        end else begin
            pc_q       <= pc_d;
            epoch_q    <= epoch_d;
            perr_q     <= perr_d;
            ifq_wp_q   <= ifq_wp_d;
            ifq_rp_q   <= ifq_rp_d;
            ifq_cnt_q  <= ifq_cnt_d;
            fifo_wp_q  <= fifo_wp_d;
            fifo_rp_q  <= fifo_rp_d;
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

    // Queue payload storage; validity is tracked by the counters only
    always_ff @(posedge clk) begin
        if (w_accept)    ifq_q[ifq_wp_q]   <= {epoch_q, pc_q};
        if (w_fifo_push) fifo_q[fifo_wp_q] <= w_push_entry;
    end

endmodule
`default_nettype wire
